// File: rtl/apb_node_timeout_demux.sv
// APB 1-to-N demux with a run-time address map. Each upstream transfer is registered,
// replayed on one downstream port and answered with PSLVERR if unmapped or if the slave hangs.
`timescale 1ns/1ps
module apb_node_timeout_demux #(
    parameter int NB_MST      = 18,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NB_MST*ADDR_W-1:0] start_addr_i,
    input  logic [NB_MST*ADDR_W-1:0] end_addr_i,
    input  logic                     s_psel_i,
    input  logic                     s_penable_i,
    input  logic                     s_pwrite_i,
    input  logic [ADDR_W-1:0]        s_paddr_i,
    input  logic [DATA_W-1:0]        s_pwdata_i,
    output logic [DATA_W-1:0]        s_prdata_o,
    output logic                     s_pready_o,
    output logic                     s_pslverr_o,
    output logic [NB_MST-1:0]        m_psel_o,
    output logic                     m_penable_o,
    output logic                     m_pwrite_o,
    output logic [ADDR_W-1:0]        m_paddr_o,
    output logic [DATA_W-1:0]        m_pwdata_o,
    input  logic [NB_MST*DATA_W-1:0] m_prdata_i,
    input  logic [NB_MST-1:0]        m_pready_i,
    input  logic [NB_MST-1:0]        m_pslverr_i,
    output logic                     err_unmapped_o,
    output logic                     err_timeout_o
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int CNT_LAST_I = TIMEOUT_EN ? TIMEOUT_CYC - 1 : 0;
    localparam int CNT_MAX_I  = TIMEOUT_EN ? TIMEOUT_CYC : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MAX_I);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DSETUP  = 2'd1,
        DACCESS = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t               state_reg;
    logic [NB_MST-1:0]    psel_reg;
    logic                 penable_reg;
    logic                 pwrite_reg;
    logic [ADDR_W-1:0]    paddr_reg;
    logic [DATA_W-1:0]    pwdata_reg;
    logic [DATA_W-1:0]    prdata_reg;
    logic                 pready_reg;
    logic                 pslverr_reg;
    logic                 unmapped_reg;
    logic                 timeout_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic [ADDR_W-1:0]    win_start [NB_MST];
    logic [ADDR_W-1:0]    win_end   [NB_MST];
    logic [DATA_W-1:0]    slv_prdata [NB_MST];
    logic [NB_MST-1:0]    hit;
    logic [NB_MST-1:0]    dec_onehot;
    logic                 dec_hit;
    logic [DATA_W-1:0]    sel_prdata;
    logic                 sel_pready;
    logic                 sel_pslverr;

    // A window with start > end can never satisfy both bounds, so it is inert.
    generate
        for (genvar gi = 0; gi < NB_MST; gi++) begin : g_win
            assign win_start[gi]  = start_addr_i[gi*ADDR_W +: ADDR_W];
            assign win_end[gi]    = end_addr_i[gi*ADDR_W +: ADDR_W];
            assign slv_prdata[gi] = m_prdata_i[gi*DATA_W +: DATA_W];
            assign hit[gi]        = (s_paddr_i >= win_start[gi]) && (s_paddr_i <= win_end[gi]);
        end
    endgenerate

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        dec_onehot = '0;
        dec_hit    = 1'b0;
        for (int i = NB_MST - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_onehot    = '0;
                dec_onehot[i] = 1'b1;
                dec_hit       = 1'b1;
            end
        end
    end

    always_comb begin
        sel_prdata = '0;
        for (int i = 0; i < NB_MST; i++) begin
            if (psel_reg[i]) begin
                sel_prdata = slv_prdata[i];
            end
        end
    end

    assign sel_pready  = |(m_pready_i & psel_reg);
    assign sel_pslverr = |(m_pslverr_i & psel_reg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            psel_reg     <= '0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            prdata_reg   <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            unmapped_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            unmapped_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s_psel_i && !s_penable_i) begin
                        if (dec_hit) begin
                            psel_reg   <= dec_onehot;
                            pwrite_reg <= s_pwrite_i;
                            paddr_reg  <= s_paddr_i;
                            pwdata_reg <= s_pwdata_i;
                            state_reg  <= DSETUP;
                        end else begin
                            pready_reg   <= 1'b1;
                            pslverr_reg  <= 1'b1;
                            prdata_reg   <= '0;
                            unmapped_reg <= 1'b1;
                            state_reg    <= RESP;
                        end
                    end
                end
                DSETUP: begin
                    penable_reg <= 1'b1;
                    cnt_reg     <= '0;
                    state_reg   <= DACCESS;
                end
                DACCESS: begin
                    // A ready on the final allowed cycle still completes normally.
                    if (sel_pready) begin
                        prdata_reg  <= sel_prdata;
                        pslverr_reg <= sel_pslverr;
                        pready_reg  <= 1'b1;
                        psel_reg    <= '0;
                        penable_reg <= 1'b0;
                        pwrite_reg  <= 1'b0;
                        paddr_reg   <= '0;
                        pwdata_reg  <= '0;
                        state_reg   <= RESP;
                    end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
                        prdata_reg  <= '0;
                        pslverr_reg <= 1'b1;
                        pready_reg  <= 1'b1;
                        timeout_reg <= 1'b1;
                        psel_reg    <= '0;
                        penable_reg <= 1'b0;
                        pwrite_reg  <= 1'b0;
                        paddr_reg   <= '0;
                        pwdata_reg  <= '0;
                        state_reg   <= RESP;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_prdata_o     = prdata_reg;
    assign s_pready_o     = pready_reg;
    assign s_pslverr_o    = pslverr_reg;
    assign m_psel_o       = psel_reg;
    assign m_penable_o    = penable_reg;
    assign m_pwrite_o     = pwrite_reg;
    assign m_paddr_o      = paddr_reg;
    assign m_pwdata_o     = pwdata_reg;
    assign err_unmapped_o = unmapped_reg;
    assign err_timeout_o  = timeout_reg;

endmodule
